fakeram_fifo_ctrl: RTL

- Initiator/controller for the 1rw1r 64x64 fake SRAM macro: presents a valid/ready streaming FIFO and stores words in the macro.
- Write side drives the rw0 port as write-only; read side drives the r0 port and absorbs its 1-cycle read latency with a 2-entry output buffer.
- Sits between a streaming producer and consumer; both macro clocks are tied to clk at the instantiating level.

---
 rtl/fakeram_fifo_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/fakeram_fifo_ctrl.sv
// fakeram_fifo_ctrl
//   Streaming FIFO controller for the 1rw1r fake SRAM macro. Words are written
//   through the rw0 port (write-only use), read back through the r0 port, and
//   the macro's 1-cycle read latency is absorbed by a 2-entry output buffer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      producer stream (push)
//   out_valid/out_ready/out_data   consumer stream (pop)
//   count                 words held: SRAM + read in flight + output buffer
//   mem_rw0_*             macro write port (ce, we, addr, wd)
//   mem_r0_*              macro read port (ce, addr out; rd in)
module fakeram_fifo_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  mem_rw0_ce,
  output logic                  mem_rw0_we,
  output logic [ADDR_WIDTH-1:0] mem_rw0_addr,
  output logic [BITS-1:0]       mem_rw0_wd,
  output logic                  mem_r0_ce,
  output logic [ADDR_WIDTH-1:0] mem_r0_addr,
  input  logic [BITS-1:0]       mem_r0_rd
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         sram_cnt_q, sram_cnt_d;
  logic                  inflight_q;
  logic [BITS-1:0]       obuf0_q, obuf0_d;   // head entry
  logic [BITS-1:0]       obuf1_q, obuf1_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;

  logic       push, pop, issue;
  logic [2:0] obuf_pend;

  // in_ready comes from registered state only: no pass-through at full.
  assign in_ready  = (sram_cnt_q < CW'(WORD_DEPTH));
  assign push      = in_valid & in_ready;
  assign out_valid = (obuf_cnt_q != 2'd0);
  assign out_data  = obuf0_q;
  assign pop       = out_valid & out_ready;

  // Slots the output buffer will need once the current pop and any pending
  // return are accounted for; out_ready reaches mem_r0_ce combinationally.
  assign obuf_pend = 3'(obuf_cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (sram_cnt_q != '0) && (obuf_pend < 3'd2);

  // Address/data are forced to 0 when idle so the macro never sees X with ce=1
  // and the bus stays quiet otherwise.
  assign mem_rw0_ce   = push;
  assign mem_rw0_we   = push;
  assign mem_rw0_addr = push ? wr_ptr_q : '0;
  assign mem_rw0_wd   = push ? in_data  : '0;
  assign mem_r0_ce    = issue;
  assign mem_r0_addr  = issue ? rd_ptr_q : '0;

  assign count = sram_cnt_q + CW'(inflight_q) + CW'(obuf_cnt_q);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    sram_cnt_d = sram_cnt_q + CW'(push) - CW'(issue);

    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;

    if (pop) begin
      obuf0_d    = obuf1_q;
      obuf_cnt_d = obuf_cnt_q - 2'd1;
    end

    // mem_r0_rd is only meaningful the cycle after an issue; the append lands
    // behind whatever survives the pop.
    if (inflight_q) begin
      if (obuf_cnt_d == 2'd0) obuf0_d = mem_r0_rd;
      else                    obuf1_d = mem_r0_rd;
      obuf_cnt_d = obuf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      obuf_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= issue;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      obuf_cnt_q <= obuf_cnt_d;
    end
  end

endmodule
